// File: rtl/mem_load_align_pkg.sv
// Shared types and codes for the memory-access stage: op encodings,
// extender select codes, FSM states and the captured-op record.
package mem_load_align_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam int DATA_W    = NUM_LANES * LANE_W;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LH  = 3'd1,
    LHU = 3'd2,
    LB  = 3'd3,
    LBU = 3'd4,
    SW  = 3'd5,
    SH  = 3'd6,
    SB  = 3'd7
  } op_e;

  // Select codes understood by the immediate extender.
  localparam logic [2:0] EXT8_S    = 3'd0;
  localparam logic [2:0] EXT8_Z    = 3'd1;
  localparam logic [2:0] EXT16_S   = 3'd2;
  localparam logic [2:0] EXT16_Z   = 3'd3;
  localparam logic [2:0] EXT32_NON = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    op_e        op;
    logic [1:0] off;
    logic [4:0] rd;
  } op_t;

  function automatic logic is_load(op_e op);
    return (op == LW) || (op == LH) || (op == LHU) || (op == LB) || (op == LBU);
  endfunction

endpackage

// File: rtl/mem_load_align_lane_sel.sv
// Byte-lane logic: store enables/replication, load slicing, extender select
// and the alignment check. Purely combinational.
module lane_sel
  import mem_load_align_pkg::*;
(
  input  logic [2:0]           i_op_type,
  input  logic [1:0]           i_off,
  input  logic [DATA_W-1:0]    i_data,
  output logic [NUM_LANES-1:0] o_be,
  output logic [DATA_W-1:0]    o_wdata,
  output logic [7:0]           o_len8,
  output logic [15:0]          o_len16,
  output logic [2:0]           o_ext,
  output logic                 o_misalign,
  output logic                 o_is_load
);

  op_e                                w_op;
  logic [NUM_LANES-1:0][LANE_W-1:0]   w_lanes;
  logic [NUM_LANES-1:0][LANE_W-1:0]   w_wlanes;

  assign w_op    = op_e'(i_op_type);
  assign w_lanes = i_data;

  assign o_len8  = w_lanes[i_off];
  assign o_len16 = i_off[1] ? {w_lanes[3], w_lanes[2]} : {w_lanes[1], w_lanes[0]};

  // Each write lane picks its source byte so the addressed lanes always see the data.
  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      assign w_wlanes[g] = (w_op == SB) ? w_lanes[0]     :
                           (w_op == SH) ? w_lanes[g % 2] :
                                          w_lanes[g];
    end
  endgenerate

  assign o_wdata   = w_wlanes;
  assign o_is_load = is_load(w_op);

  always_comb begin
    o_be       = '1;
    o_ext      = EXT32_NON;
    o_misalign = 1'b0;
    case (w_op)
      LB:  o_ext = EXT8_S;
      LBU: o_ext = EXT8_Z;
      LH: begin
        o_ext      = EXT16_S;
        o_misalign = i_off[0];
      end
      LHU: begin
        o_ext      = EXT16_Z;
        o_misalign = i_off[0];
      end
      LW:  o_misalign = |i_off;
      SW:  o_misalign = |i_off;
      SH: begin
        o_be       = i_off[1] ? 4'b1100 : 4'b0011;
        o_misalign = i_off[0];
      end
      SB:  o_be = 4'b0001 << i_off;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_load_align.sv
// Memory-access stage: one load/store at a time over a req/ack memory port,
// result handed to the extender, misaligned ops trapped before memory.
module mem_load_align
  import mem_load_align_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_type,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [31:0]       op_wdata,
  input  logic [4:0]        op_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_is_load,
  output logic [4:0]        res_rd,
  output logic [2:0]        ext_switch,
  output logic [7:0]        res_len8,
  output logic [15:0]       res_len16,
  output logic [31:0]       res_len32,
  output logic              exc_misalign,
  output logic [ADDR_W-1:0] exc_addr
);

  state_e            r_state, w_state_nxt;
  op_t               r_op;
  logic              w_idle, w_accept, w_mis_fire, w_ack;
  logic [2:0]        w_ls_type;
  logic [1:0]        w_ls_off;
  logic [31:0]       w_ls_data;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [7:0]        w_len8;
  logic [15:0]       w_len16;
  logic [2:0]        w_ext;
  logic              w_misalign, w_is_load;

  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [3:0]        r_mem_be;
  logic [31:0]       r_mem_wdata;
  logic              r_res_is_load;
  logic [4:0]        r_res_rd;
  logic [2:0]        r_ext;
  logic [7:0]        r_len8;
  logic [15:0]       r_len16;
  logic [31:0]       r_len32;
  logic              r_exc;
  logic [ADDR_W-1:0] r_exc_addr;

  assign w_idle = (r_state == ST_IDLE);

  // One lane_sel serves both directions: incoming op while idle, captured op during REQ.
  assign w_ls_type = w_idle ? op_type      : r_op.op;
  assign w_ls_off  = w_idle ? op_addr[1:0] : r_op.off;
  assign w_ls_data = w_idle ? op_wdata     : mem_rdata;

  lane_sel u_lane_sel (
    .i_op_type  (w_ls_type),
    .i_off      (w_ls_off),
    .i_data     (w_ls_data),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_len8     (w_len8),
    .o_len16    (w_len16),
    .o_ext      (w_ext),
    .o_misalign (w_misalign),
    .o_is_load  (w_is_load)
  );

  assign w_accept   = op_valid & w_idle & ~w_misalign;
  assign w_mis_fire = op_valid & w_idle &  w_misalign;
  assign w_ack      = (r_state == ST_REQ) & mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_state_nxt = ST_REQ;
      ST_REQ:  if (mem_ack)   w_state_nxt = ST_RESP;
      ST_RESP: if (res_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    op_ready  = (r_state == ST_IDLE);
    mem_req   = (r_state == ST_REQ);
    res_valid = (r_state == ST_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= '{op: LW, off: 2'b00, rd: 5'd0};
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
    end else if (w_accept) begin
      r_op        <= '{op: op_e'(op_type), off: op_addr[1:0], rd: op_rd};
      r_mem_we    <= ~w_is_load;
      r_mem_addr  <= {op_addr[ADDR_W-1:2], 2'b00};
      r_mem_be    <= w_be;
      r_mem_wdata <= w_wdata;
    end
  end

  // Store completions report zero data so the extender sees a clean word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_is_load <= 1'b0;
      r_res_rd      <= '0;
      r_ext         <= EXT32_NON;
      r_len8        <= '0;
      r_len16       <= '0;
      r_len32       <= '0;
    end else if (w_ack) begin
      r_res_is_load <= w_is_load;
      r_res_rd      <= r_op.rd;
      r_ext         <= w_ext;
      r_len8        <= w_is_load ? w_len8    : '0;
      r_len16       <= w_is_load ? w_len16   : '0;
      r_len32       <= w_is_load ? mem_rdata : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exc      <= 1'b0;
      r_exc_addr <= '0;
    end else begin
      r_exc <= w_mis_fire;
      if (w_mis_fire) r_exc_addr <= op_addr;
    end
  end

  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_be       = r_mem_be;
  assign mem_wdata    = r_mem_wdata;
  assign res_is_load  = r_res_is_load;
  assign res_rd       = r_res_rd;
  assign ext_switch   = r_ext;
  assign res_len8     = r_len8;
  assign res_len16    = r_len16;
  assign res_len32    = r_len32;
  assign exc_misalign = r_exc;
  assign exc_addr     = r_exc_addr;

endmodule

// File: tb/tb_mem_load_align.sv
// Bench for mem_load_align: directed test-plan scenarios plus random ops
// checked against an arithmetic reference of the lane rules.
module tb_mem_load_align;
  import mem_load_align_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  op_type = 3'd0;
  logic [31:0] op_addr = '0;
  logic [31:0] op_wdata = '0;
  logic [4:0]  op_rd = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        res_is_load;
  logic [4:0]  res_rd;
  logic [2:0]  ext_switch;
  logic [7:0]  res_len8;
  logic [15:0] res_len16;
  logic [31:0] res_len32;
  logic        exc_misalign;
  logic [31:0] exc_addr;

  int checks = 0;
  int errors = 0;

  mem_load_align #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type),
    .op_addr(op_addr), .op_wdata(op_wdata), .op_rd(op_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_is_load(res_is_load),
    .res_rd(res_rd), .ext_switch(ext_switch), .res_len8(res_len8),
    .res_len16(res_len16), .res_len32(res_len32),
    .exc_misalign(exc_misalign), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  // Reference rules, written directly from the op semantics.
  function automatic logic m_load(op_e op);
    return (op == LW) || (op == LH) || (op == LHU) || (op == LB) || (op == LBU);
  endfunction

  function automatic logic m_mis(op_e op, logic [31:0] a);
    if (op == LW || op == SW) return (a % 4) != 0;
    if (op == LH || op == LHU || op == SH) return (a % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(op_e op, logic [31:0] a);
    if (op == SB) return 4'(1 << (a % 4));
    if (op == SH) return ((a % 4) >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(op_e op, logic [31:0] wd);
    if (op == SB) return (wd % 256) * 32'h0101_0101;
    if (op == SH) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [2:0] m_ext(op_e op);
    case (op)
      LB:      return EXT8_S;
      LBU:     return EXT8_Z;
      LH:      return EXT16_S;
      LHU:     return EXT16_Z;
      default: return EXT32_NON;
    endcase
  endfunction

  // Drives one op through the whole handshake and checks every phase against the model.
  task automatic do_op(input op_e op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rdata, input logic [4:0] rd,
                       input int ack_dly, input int rdy_dly,
                       output logic [7:0] o8, output logic [15:0] o16, output logic [2:0] oext);
    logic        ld, mis;
    logic [7:0]  e8;
    logic [15:0] e16;
    logic [31:0] e32;
    ld  = m_load(op);
    mis = m_mis(op, a);
    e8  = ld ? 8'((rdata >> (8 * (a % 4))) & 32'hFF) : 8'h0;
    e16 = ld ? 16'((rdata >> (16 * ((a % 4) / 2))) & 32'hFFFF) : 16'h0;
    e32 = ld ? rdata : 32'h0;
    o8 = 'x; o16 = 'x; oext = 'x;
    @(negedge clk);
    checks++;
    if (op_ready !== 1'b1) begin errors++; $display("FAIL op_ready_before got=%b exp=1", op_ready); end
    op_valid = 1'b1; op_type = op; op_addr = a; op_wdata = wd; op_rd = rd;
    @(negedge clk);
    op_valid = 1'b0; op_type = 3'($urandom); op_addr = $urandom; op_wdata = $urandom; op_rd = 5'($urandom);
    if (mis) begin
      checks++;
      if (exc_misalign !== 1'b1 || exc_addr !== a) begin
        errors++; $display("FAIL exc_pulse got=%b/%h exp=1/%h", exc_misalign, exc_addr, a);
      end
      checks++;
      if (mem_req !== 1'b0 || op_ready !== 1'b1) begin
        errors++; $display("FAIL mis_no_req req=%b ready=%b exp=0/1", mem_req, op_ready);
      end
      @(negedge clk);
      checks++;
      if (exc_misalign !== 1'b0 || res_valid !== 1'b0 || mem_req !== 1'b0 || exc_addr !== a) begin
        errors++; $display("FAIL exc_after exc=%b rv=%b req=%b addr=%h exp=0/0/0/%h",
                           exc_misalign, res_valid, mem_req, exc_addr, a);
      end
      return;
    end
    checks++;
    if (mem_req !== 1'b1 || op_ready !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL req_start req=%b ready=%b rv=%b exp=1/0/0", mem_req, op_ready, res_valid);
    end
    checks++;
    if (mem_we !== !ld || mem_addr !== {a[31:2], 2'b00} || mem_be !== m_be(op, a)) begin
      errors++; $display("FAIL mem_fields we=%b addr=%h be=%b exp=%b/%h/%b",
                         mem_we, mem_addr, mem_be, !ld, {a[31:2], 2'b00}, m_be(op, a));
    end
    if (!ld) begin
      checks++;
      if (mem_wdata !== m_wd(op, wd)) begin
        errors++; $display("FAIL mem_wdata got=%h exp=%h", mem_wdata, m_wd(op, wd));
      end
    end
    repeat (ack_dly) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== {a[31:2], 2'b00} || mem_be !== m_be(op, a) ||
          mem_we !== !ld || res_valid !== 1'b0) begin
        errors++; $display("FAIL req_hold req=%b addr=%h be=%b rv=%b exp=1/%h/%b/0",
                           mem_req, mem_addr, mem_be, res_valid, {a[31:2], 2'b00}, m_be(op, a));
      end
    end
    mem_ack = 1'b1; mem_rdata = rdata;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = $urandom;
    for (int k = 0; k <= rdy_dly; k++) begin
      checks++;
      if (res_valid !== 1'b1 || mem_req !== 1'b0 || op_ready !== 1'b0) begin
        errors++; $display("FAIL resp_state rv=%b req=%b ready=%b exp=1/0/0 cyc=%0d",
                           res_valid, mem_req, op_ready, k);
      end
      checks++;
      if (res_is_load !== ld || res_rd !== rd || ext_switch !== m_ext(op) ||
          res_len8 !== e8 || res_len16 !== e16 || res_len32 !== e32) begin
        errors++; $display("FAIL resp_data ld=%b rd=%0d ext=%0d b=%h h=%h w=%h exp=%b/%0d/%0d/%h/%h/%h",
                           res_is_load, res_rd, ext_switch, res_len8, res_len16, res_len32,
                           ld, rd, m_ext(op), e8, e16, e32);
      end
      if (k == 0) begin o8 = res_len8; o16 = res_len16; oext = ext_switch; end
      if (k < rdy_dly) @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || op_ready !== 1'b1) begin
      errors++; $display("FAIL resp_done rv=%b ready=%b exp=0/1", res_valid, op_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (op_ready !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || res_valid !== 1'b0 ||
        res_is_load !== 1'b0 || exc_misalign !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl ready=%b req=%b we=%b rv=%b ld=%b exc=%b exp=1/0/0/0/0/0",
                         op_ready, mem_req, mem_we, res_valid, res_is_load, exc_misalign);
    end
    checks++;
    if (mem_addr !== 0 || mem_be !== 0 || mem_wdata !== 0 || res_rd !== 0 || res_len8 !== 0 ||
        res_len16 !== 0 || res_len32 !== 0 || exc_addr !== 0 || ext_switch !== EXT32_NON) begin
      errors++; $display("FAIL reset_data addr=%h be=%b wd=%h rd=%0d w=%h ea=%h ext=%0d exp=zeros ext=%0d",
                         mem_addr, mem_be, mem_wdata, res_rd, res_len32, exc_addr, ext_switch, EXT32_NON);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lb();
    logic [7:0] b; logic [15:0] h; logic [2:0] e;
    do_op(LB, 32'h1003, 32'h0, 32'h80FF_1234, 5'd3, 0, 0, b, h, e);
    checks++;
    if (b !== 8'h80 || e !== EXT8_S) begin
      errors++; $display("FAIL lb_plan b=%h ext=%0d exp=80/%0d", b, e, EXT8_S);
    end
  endtask

  task automatic test_lhu_delayed();
    logic [7:0] b; logic [15:0] h; logic [2:0] e;
    do_op(LHU, 32'h2002, 32'h0, 32'hBEEF_0000, 5'd9, 3, 0, b, h, e);
    checks++;
    if (h !== 16'hBEEF || e !== EXT16_Z) begin
      errors++; $display("FAIL lhu_plan h=%h ext=%0d exp=beef/%0d", h, e, EXT16_Z);
    end
  endtask

  task automatic test_sb();
    logic [7:0] b; logic [15:0] h; logic [2:0] e;
    do_op(SB, 32'h10, 32'h0000_00A5, 32'h1234_5678, 5'd4, 1, 0, b, h, e);
    do_op(SH, 32'h12, 32'hFFFF_C3D4, 32'h0, 5'd5, 0, 0, b, h, e);
    do_op(SW, 32'h20, 32'hDEAD_BEEF, 32'h0, 5'd6, 2, 1, b, h, e);
  endtask

  task automatic test_misalign();
    logic [7:0] b; logic [15:0] h; logic [2:0] e;
    do_op(LW, 32'h0006, 32'h0, 32'h0, 5'd1, 0, 0, b, h, e);
    do_op(SH, 32'h0101, 32'h0, 32'h0, 5'd1, 0, 0, b, h, e);
    checks++;
    if (op_ready !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL mis_idle ready=%b req=%b exp=1/0", op_ready, mem_req);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] b; logic [15:0] h; logic [2:0] e;
    do_op(LH, 32'h3002, 32'h0, 32'h8001_7F00, 5'd17, 1, 4, b, h, e);
    checks++;
    if (h !== 16'h8001 || e !== EXT16_S) begin
      errors++; $display("FAIL bp_plan h=%h ext=%0d exp=8001/%0d", h, e, EXT16_S);
    end
  endtask

  task automatic test_spurious();
    @(negedge clk);
    mem_ack = 1'b1; res_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || mem_req !== 1'b0 || op_ready !== 1'b1) begin
        errors++; $display("FAIL spurious rv=%b req=%b ready=%b exp=0/0/1", res_valid, mem_req, op_ready);
      end
    end
    mem_ack = 1'b0; res_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] b; logic [15:0] h; logic [2:0] e;
    for (int i = 0; i < 60; i++) begin
      do_op(op_e'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 5'($urandom),
            $urandom_range(0, 3), $urandom_range(0, 2), b, h, e);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    op_valid = 1'b1; op_type = LW; op_addr = 32'h40; op_rd = 5'd7;
    @(negedge clk);
    op_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_req got=%b exp=1", mem_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || op_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_async req=%b ready=%b exp=0/1", mem_req, op_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (3) begin
      @(negedge clk);
      mem_ack = 1'b0;
      checks++;
      if (res_valid !== 1'b0 || exc_misalign !== 1'b0 || mem_req !== 1'b0 || op_ready !== 1'b1) begin
        errors++; $display("FAIL rst_mid_after rv=%b exc=%b req=%b ready=%b exp=0/0/0/1",
                           res_valid, exc_misalign, mem_req, op_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_lhu_delayed();
    test_sb();
    test_misalign();
    test_backpressure();
    test_spurious();
    test_random();
    test_reset_mid();
    test_lb();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
